i2s_transmitter: RTL and testbench

- Counterpart of the I2S microphone receiver. Serialises stereo 24-bit samples to an external I2S DAC.
- Acts as bus master: generates sclk_out and ws_out from the system clock, and drives sdata_out MSB-first in standard Philips I2S framing.
- Sits downstream of the processing pipeline. A one-entry holding register decouples the valid/ready producer from the fixed frame rate.

---
 rtl/i2s_pkg.sv | 32 +++
 rtl/i2s_clk_gen.sv | 46 ++++
 rtl/i2s_transmitter.sv | 155 +++++++++++++++
 tb/tb_i2s_transmitter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Shared I2S framing constants and types for the transmitter and receiver.
//   A Philips I2S frame is two 32-bit slots (left first). Samples sit
//   left-justified in their slot, and the unused LSBs are zero.
package i2s_pkg;

  localparam int SLOT_BITS     = 32;
  localparam int FRAME_BITS    = 64;
  localparam int BIT_CNT_W     = 6;

  // WS is high over this range of bit-counter values. It leads each
  // channel's MSB by one sclk.
  localparam int WS_HIGH_FIRST = 31;
  localparam int WS_HIGH_LAST  = 62;

  // Slot-wide, left-justified stereo pair. With {left, right} packed in this
  // order, the struct has the same bit layout as a frame.
  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  function automatic logic ws_for_bit(input logic [BIT_CNT_W-1:0] c);
    return (c >= BIT_CNT_W'(WS_HIGH_FIRST)) && (c <= BIT_CNT_W'(WS_HIGH_LAST));
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen
//   Divides the system clock down to the I2S bit clock. It also emits
//   single-cycle strobes on the system-clock cycle where sclk is about to
//   fall or rise. Serial logic can then stay on clk_in.
//
// Ports
//   clk_in    : system clock
//   rst_in    : asynchronous active-low reset
//   sclk_out  : bit clock, f_clk / (2*CLK_DIV), low out of reset
//   fall_stb  : high in the cycle whose closing edge drives sclk 1 -> 0
//   rise_stb  : high in the cycle whose closing edge drives sclk 0 -> 1
module i2s_clk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic sclk_out,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap = (r_div_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  assign sclk_out = r_sclk;
  assign fall_stb = w_wrap & r_sclk;
  assign rise_stb = w_wrap & ~r_sclk;

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter
//   I2S bus-master transmitter. It takes stereo sample pairs through a
//   valid/ready handshake into a one-entry holding register, and it
//   serialises them MSB-first in Philips I2S framing at a fixed frame rate.
//
// Ports
//   clk_in          : system clock
//   rst_in          : asynchronous active-low reset
//   left_in         : left sample, two's complement, SAMPLE_WIDTH bits
//   right_in        : right sample, two's complement, SAMPLE_WIDTH bits
//   valid_in        : sample pair valid
//   ready_out       : holding register empty (accept = valid_in & ready_out)
//   sclk_out        : I2S bit clock
//   ws_out          : word select, 0 = left, 1 = right
//   sdata_out       : serial data, updated at sclk falling edges
//   frame_start_out : one-clk pulse in the cycle a new frame is loaded
//   underrun_out    : one-clk pulse when that load finds the holding reg empty
//
// Holding register FSM
//   state      | meaning
//   HOLD_EMPTY | no pair waiting; ready_out high, next load sends zeros
//   HOLD_FULL  | pair waiting for the next frame load; ready_out low
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int CLK_DIV      = 16,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    sclk_out,
  output logic                    ws_out,
  output logic                    sdata_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  logic                  w_fall_stb;
  logic                  w_rise_stb;

  hold_state_t           r_hold_state;
  hold_state_t           w_hold_state_nxt;
  stereo_sample_t        r_hold;
  stereo_sample_t        w_pair;

  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [BIT_CNT_W-1:0]  w_bit_nxt;
  logic [FRAME_BITS-1:0] r_frame;
  logic [FRAME_BITS-1:0] w_frame_nxt;
  logic                  r_ws;
  logic                  r_sdata;

  logic                  w_load;
  logic                  w_accept;
  logic                  w_empty;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sclk_out (sclk_out),
    .fall_stb (w_fall_stb),
    .rise_stb (w_rise_stb)
  );

  // The two strobes come from opposite sclk phases and can never coincide.
  always_comb begin
    assert (!(w_fall_stb && w_rise_stb));
  end

  // Left-justify the samples in their slots. The cast zero-extends, so
  // nothing leaks into the padding and no sign extension takes place.
  assign w_pair.left  = SLOT_BITS'(left_in)  << (SLOT_BITS - SAMPLE_WIDTH);
  assign w_pair.right = SLOT_BITS'(right_in) << (SLOT_BITS - SAMPLE_WIDTH);

  // ---------------------------------------------------------------------
  // Bit counter and frame load
  // ---------------------------------------------------------------------
  // The counter wraps 63 -> 0 on its own (6-bit add), and the wrap is the
  // frame boundary.
  assign w_bit_nxt = r_bit_cnt + BIT_CNT_W'(1);
  assign w_load    = w_fall_stb && (w_bit_nxt == '0);

  // The new frame is visible combinationally so that the left MSB leaves on
  // the same edge that loads it.
  always_comb begin
    w_frame_nxt = r_frame;
    if (w_load) begin
      w_frame_nxt = (r_hold_state == HOLD_FULL) ? r_hold : '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
      r_frame   <= '0;
      r_ws      <= 1'b0;
      r_sdata   <= 1'b0;
    end else if (w_fall_stb) begin
      r_bit_cnt <= w_bit_nxt;
      r_frame   <= w_frame_nxt;
      r_ws      <= ws_for_bit(w_bit_nxt);
      r_sdata   <= w_frame_nxt[BIT_CNT_W'(FRAME_BITS - 1) - w_bit_nxt];
    end
  end

  assign ws_out    = r_ws;
  assign sdata_out = r_sdata;

  // ---------------------------------------------------------------------
  // Holding register FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hold_state <= HOLD_EMPTY;
    end else begin
      r_hold_state <= w_hold_state_nxt;
    end
  end

  // A load and an accept cannot both change state in one cycle. An accept
  // needs EMPTY, and a load only empties a FULL register. When an accept
  // lands on an empty load, the load sends zeros and the pair stays for
  // the next frame.
  always_comb begin
    w_hold_state_nxt = r_hold_state;
    case (r_hold_state)
      HOLD_EMPTY: if (valid_in) w_hold_state_nxt = HOLD_FULL;
      HOLD_FULL:  if (w_load)   w_hold_state_nxt = HOLD_EMPTY;
      default:                  w_hold_state_nxt = HOLD_EMPTY;
    endcase
  end

  always_comb begin
    w_empty         = (r_hold_state == HOLD_EMPTY);
    ready_out       = w_empty;
    w_accept        = w_empty && valid_in;
    frame_start_out = w_load;
    underrun_out    = w_load && w_empty;
  end

  // The holding data has no reset. It is only read while FULL, and FULL is
  // only reached by an accept that writes it.
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_hold <= w_pair;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
module tb_i2s_transmitter;

  localparam int CLK_DIV    = 2;
  localparam int SW         = 24;
  localparam int FRAME_CLKS = 128 * CLK_DIV;
  // ws per captured bit, stored at index 63-k for bit k: high for k = 31..62
  localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

  logic          clk_in   = 1'b0;
  logic          rst_in   = 1'b1;
  logic [SW-1:0] left_in  = '0;
  logic [SW-1:0] right_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic          sclk_out;
  logic          ws_out;
  logic          sdata_out;
  logic          frame_start_out;
  logic          underrun_out;

  always #5 clk_in = ~clk_in;

  i2s_transmitter #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_WIDTH (SW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .left_in         (left_in),
    .right_in        (right_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .sclk_out        (sclk_out),
    .ws_out          (ws_out),
    .sdata_out       (sdata_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc      = 0;
  logic          prev_sclk = 1'b0;
  logic          sclk_rise = 1'b0;

  bit            bp_en = 1'b0;
  logic [SW-1:0] bp_val = '0;
  logic [63:0]   exp_q[$];
  int            acc_cnt = 0;

  bit            inj_on_load = 1'b0;
  int            inj_cyc = -1;
  bit            inj_clr = 1'b0;
  logic [47:0]   inj_pair = '0;

  function automatic logic [63:0] fr(input logic [SW-1:0] l, input logic [SW-1:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One system clock. Outputs are sampled at the falling clk edge, and
  // inputs are changed right after so that the next rising edge sees them.
  task automatic step();
    @(negedge clk_in);
    cyc++;
    sclk_rise = sclk_out && !prev_sclk;
    prev_sclk = sclk_out;
    if (inj_clr) begin
      valid_in = 1'b0;
      inj_clr  = 1'b0;
    end
    if ((inj_on_load && frame_start_out === 1'b1) || cyc == inj_cyc) begin
      {left_in, right_in} = inj_pair;
      valid_in    = 1'b1;
      inj_clr     = 1'b1;
      inj_on_load = 1'b0;
    end
    if (bp_en) begin
      bp_val++;
      left_in  = bp_val;
      right_in = ~bp_val;
      valid_in = 1'b1;
      if (ready_out === 1'b1) begin
        exp_q.push_back(fr(left_in, right_in));
        acc_cnt++;
      end
    end
  endtask

  task automatic supply(input logic [SW-1:0] l, input logic [SW-1:0] r);
    left_in  = l;
    right_in = r;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    chk("rst_async", {sclk_out, ws_out, sdata_out, frame_start_out, underrun_out, ready_out}, 6'b000001);
    repeat (10) step();
    chk("rst_hold", {sclk_out, ws_out, sdata_out, frame_start_out, underrun_out, ready_out}, 6'b000001);
    rst_in = 1'b1;
  endtask

  // Checks the first three cycles after release: sclk rises after CLK_DIV
  // clks, and the first load is in flight in cycle 3 (it completes at 4).
  task automatic check_restart(input string tag);
    logic [2:0] fs_v;
    logic [2:0] sc_v;
    for (int i = 0; i < 3; i++) begin
      step();
      fs_v[2-i] = frame_start_out;
      sc_v[2-i] = sclk_out;
    end
    chk({tag, "_fs_first"}, fs_v, 3'b001);
    chk({tag, "_sclk_start"}, sc_v, 3'b011);
  endtask

  // Waits for a frame load, then records the 64 bits seen at sclk rising
  // edges. Bit k goes to index 63-k, so d lines up with the frame layout.
  task automatic capture(input string tag, output logic [63:0] d, output logic [63:0] w,
                         output logic ur, output int start_cyc);
    int n;
    int k;
    n = 0;
    k = 0;
    d = '0;
    w = '0;
    ur = 1'bx;
    start_cyc = cyc;
    while (frame_start_out !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    if (frame_start_out !== 1'b1) begin
      chk({tag, "_start_timeout"}, 64'd0, 64'd1);
    end else begin
      ur = underrun_out;
      start_cyc = cyc;
      acc_cnt = 0;
      n = 0;
      while (k < 64 && n < 1000) begin
        step();
        n++;
        if (sclk_rise) begin
          d[63-k] = sdata_out;
          w[63-k] = ws_out;
          k++;
        end
      end
      if (k != 64) chk({tag, "_bits_timeout"}, 64'(k), 64'd64);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] w;
    logic [63:0] e;
    logic        ur;
    int          s0;
    int          s1;
    int          r;
    int          n;

    #2;
    // ---- reset / idle ----
    do_reset();
    check_restart("idle");
    capture("idle0", d, w, ur, s0);
    chk("idle0_data", d, 64'd0);
    chk("idle0_ws", w, WS_EXP);
    chk("idle0_underrun", 64'(ur), 64'd1);
    capture("idle1", d, w, ur, s1);
    chk("idle1_data", d, 64'd0);
    chk("idle1_underrun", 64'(ur), 64'd1);
    chk("idle_frame_period", 64'(s1 - s0), 64'(FRAME_CLKS));

    // ---- basic frame, pair loaded before the first load ----
    do_reset();
    supply(24'hA50F3C, 24'h800001);
    chk("basic_ready_low", 64'(ready_out), 64'd0);
    capture("basic", d, w, ur, s0);
    chk("basic_data", d, 64'hA50F3C00_80000100);
    chk("basic_ws", w, WS_EXP);
    chk("basic_underrun", 64'(ur), 64'd0);

    // ---- underrun then recovery ----
    supply(24'h123456, 24'hFEDCBA);
    capture("ur1", d, w, ur, s0);
    chk("ur1_data", d, 64'h12345600_FEDCBA00);
    chk("ur1_underrun", 64'(ur), 64'd0);
    capture("ur2", d, w, ur, s0);
    chk("ur2_data", d, 64'd0);
    chk("ur2_underrun", 64'(ur), 64'd1);
    inj_pair = {24'h7FFFFF, 24'h000080};
    inj_cyc  = cyc + 100;
    capture("ur3", d, w, ur, s0);
    chk("ur3_data", d, 64'd0);
    chk("ur3_underrun", 64'(ur), 64'd1);
    capture("ur4", d, w, ur, s0);
    chk("ur4_data", d, 64'h7FFFFF00_00008000);
    chk("ur4_underrun", 64'(ur), 64'd0);

    // ---- accept in the very cycle of an empty load ----
    inj_pair    = {24'hC0FFEE, 24'h5A5A5A};
    inj_on_load = 1'b1;
    capture("sim0", d, w, ur, s0);
    chk("sim0_data", d, 64'd0);
    chk("sim0_underrun", 64'(ur), 64'd1);
    capture("sim1", d, w, ur, s0);
    chk("sim1_data", d, 64'hC0FFEE00_5A5A5A00);
    chk("sim1_underrun", 64'(ur), 64'd0);

    // ---- back-pressure: valid held high with a new pair every cycle ----
    n = 0;
    while (frame_start_out !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    step();
    bp_val = 24'h000100;
    bp_en  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      capture("bp", d, w, ur, s0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
      if (f == 0) chk("bp_first_pair", e, fr(24'h000101, 24'hFFFEFE));
      chk("bp_data", d, e);
      chk("bp_accepts_per_frame", 64'(acc_cnt), 64'd1);
      chk("bp_underrun", 64'(ur), 64'd0);
    end
    bp_en    = 1'b0;
    valid_in = 1'b0;
    capture("bp_drain", d, w, ur, s0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    chk("bp_drain_data", d, e);
    chk("bp_drain_underrun", 64'(ur), 64'd0);

    // ---- reset at bit 40 of a data frame, with a stale pair held ----
    supply(24'h3C3C3C, 24'hFFFFFF);
    chk("mid_load", 64'(frame_start_out), 64'd1);
    r = 0;
    step();
    if (sclk_rise) r++;
    supply(24'h7ABCDE, 24'h7ABCDE);
    if (sclk_rise) r++;
    chk("mid_stale_held", 64'(ready_out), 64'd0);
    n = 0;
    while (r < 41 && n < 1000) begin
      step();
      n++;
      if (sclk_rise) r++;
    end
    chk("mid_reach_bit40", 64'(r), 64'd41);
    chk("mid_pre_reset", {sclk_out, ws_out, sdata_out}, 3'b111);
    do_reset();
    check_restart("mid");
    capture("mid_after", d, w, ur, s0);
    chk("mid_after_data", d, 64'd0);
    chk("mid_after_ws", w, WS_EXP);
    chk("mid_after_underrun", 64'(ur), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
